// File: rtl/aliens_io_regs.sv
// I/O register block behind the main-CPU decoder: control, sound latch, coin stretchers, watchdog, input mux.
// Latency: writes and reads take effect on the edge after the strobe, so read data is valid one cycle later.
// Backpressure: none; the CPU bus is never stalled, and a write held for many cycles acts only once.
module aliens_io_regs #(
    parameter int COIN_PULSE = 16,
    parameter int WDOG_MAX   = 65535,
    parameter int WDOG_PULSE = 8
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       IOCS,
    input  logic       WR_n,
    input  logic [2:0] ADDR,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DOUT_EN,
    input  logic [7:0] SYS,
    input  logic [7:0] P1,
    input  logic [7:0] P2,
    input  logic [7:0] DSW1,
    input  logic [7:0] DSW2,
    output logic       RMRD,
    output logic       COIN1,
    output logic       COIN2,
    output logic [7:0] SND_DATA,
    output logic       SND_IRQ,
    input  logic       SND_ACK,
    output logic       WDOG_RST
);

    localparam int CW = $clog2(COIN_PULSE + 1);
    localparam int WW = $clog2(WDOG_MAX + 1);
    localparam int PW = $clog2(WDOG_PULSE + 1);

    logic          acc;
    logic          wr_cond;
    logic          rd_cond;
    logic          wr_prev;
    logic          wr_evt;
    logic          wr_ctrl;
    logic          wr_snd;
    logic          kick;

    logic [1:0]    coin_bit;
    logic [CW-1:0] coin_cnt [2];
    logic          rmrd_q;

    logic [WW-1:0] wdog_cnt;
    logic [PW-1:0] pulse_cnt;
    logic          wdog_rst_q;

    logic [7:0]    rd_mux;
    logic          unused_din;

    assign acc     = ~IOCS;
    assign wr_cond = acc & ~WR_n;
    assign rd_cond = acc & WR_n;
    assign wr_evt  = wr_cond & ~wr_prev;
    assign wr_ctrl = wr_evt & (ADDR == 3'd0);
    assign wr_snd  = wr_evt & (ADDR == 3'd1);
    assign kick    = wr_evt & (ADDR == 3'd2);

    assign unused_din = ^{DIN[7:6], DIN[4:2]};

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_prev <= 1'b0;
        end else begin
            wr_prev <= wr_cond;
        end
    end

    // Control register plus one retriggerable stretcher per coin counter.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            coin_bit <= 2'b00;
            rmrd_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                coin_cnt[i] <= '0;
            end
        end else begin
            if (wr_ctrl) begin
                coin_bit <= DIN[1:0];
                rmrd_q   <= DIN[5];
            end
            for (int i = 0; i < 2; i++) begin
                if (wr_ctrl && DIN[i] && !coin_bit[i]) begin
                    coin_cnt[i] <= CW'(COIN_PULSE);
                end else if (coin_cnt[i] != '0) begin
                    coin_cnt[i] <= coin_cnt[i] - CW'(1);
                end
            end
        end
    end

    assign RMRD  = rmrd_q;
    assign COIN1 = coin_bit[0] | (coin_cnt[0] != '0);
    assign COIN2 = coin_bit[1] | (coin_cnt[1] != '0);

    // A write in the same cycle as the acknowledge keeps the request raised.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            SND_DATA <= 8'h00;
            SND_IRQ  <= 1'b0;
        end else if (wr_snd) begin
            SND_DATA <= DIN;
            SND_IRQ  <= 1'b1;
        end else if (SND_ACK) begin
            SND_IRQ  <= 1'b0;
        end
    end

    // While the pulse runs the counter is frozen and kicks are ignored.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wdog_cnt   <= '0;
            pulse_cnt  <= '0;
            wdog_rst_q <= 1'b0;
        end else if (wdog_rst_q) begin
            if (pulse_cnt <= PW'(1)) begin
                wdog_rst_q <= 1'b0;
            end
            if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - PW'(1);
            end
        end else if (kick) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt >= WW'(WDOG_MAX - 1)) begin
            wdog_cnt   <= '0;
            pulse_cnt  <= PW'(WDOG_PULSE);
            wdog_rst_q <= 1'b1;
        end else begin
            wdog_cnt <= wdog_cnt + WW'(1);
        end
    end

    assign WDOG_RST = wdog_rst_q;

    always_comb begin
        rd_mux = 8'hFF;
        case (ADDR)
            3'd0:    rd_mux = SYS;
            3'd1:    rd_mux = P1;
            3'd2:    rd_mux = P2;
            3'd3:    rd_mux = DSW1;
            3'd4:    rd_mux = DSW2;
            default: rd_mux = 8'hFF;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            DOUT    <= 8'h00;
            DOUT_EN <= 1'b0;
        end else if (rd_cond) begin
            DOUT    <= rd_mux;
            DOUT_EN <= 1'b1;
        end else begin
            DOUT_EN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aliens_io_regs.sv
// Directed bench for aliens_io_regs with short coin/watchdog parameters.
module tb_aliens_io_regs;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       IOCS;
    logic       WR_n;
    logic [2:0] ADDR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       DOUT_EN;
    logic [7:0] SYS, P1, P2, DSW1, DSW2;
    logic       RMRD, COIN1, COIN2;
    logic [7:0] SND_DATA;
    logic       SND_IRQ;
    logic       SND_ACK;
    logic       WDOG_RST;

    int checks = 0;
    int errors = 0;

    aliens_io_regs #(
        .COIN_PULSE(16),
        .WDOG_MAX  (100),
        .WDOG_PULSE(8)
    ) dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .IOCS    (IOCS),
        .WR_n    (WR_n),
        .ADDR    (ADDR),
        .DIN     (DIN),
        .DOUT    (DOUT),
        .DOUT_EN (DOUT_EN),
        .SYS     (SYS),
        .P1      (P1),
        .P2      (P2),
        .DSW1    (DSW1),
        .DSW2    (DSW2),
        .RMRD    (RMRD),
        .COIN1   (COIN1),
        .COIN2   (COIN2),
        .SND_DATA(SND_DATA),
        .SND_IRQ (SND_IRQ),
        .SND_ACK (SND_ACK),
        .WDOG_RST(WDOG_RST)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        IOCS = 1'b0; WR_n = 1'b0; ADDR = a; DIN = d;
        tick();
        IOCS = 1'b1; WR_n = 1'b1;
    endtask

    function automatic logic [21:0] out_vec();
        return {RMRD, COIN1, COIN2, SND_DATA, SND_IRQ, WDOG_RST, DOUT, DOUT_EN};
    endfunction

    task automatic test_reset();
        logic bad;
        RST_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            IOCS = 1'($urandom); WR_n = 1'($urandom); ADDR = 3'($urandom);
            DIN = 8'($urandom); SND_ACK = 1'($urandom);
            SYS = 8'($urandom); P1 = 8'($urandom); P2 = 8'($urandom);
            DSW1 = 8'($urandom); DSW2 = 8'($urandom);
            tick();
        end
        checks++;
        if (out_vec() !== 22'h0) begin
            errors++; $display("FAIL reset_state: got %h want 000000", out_vec());
        end
        IOCS = 1'b1; WR_n = 1'b1; ADDR = 3'd0; DIN = 8'h00; SND_ACK = 1'b0;
        RST_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_vec() !== 22'h0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL reset_idle: got %h want 000000", out_vec());
        end
    endtask

    task automatic test_reads();
        logic [2:0] addrs [6];
        logic [7:0] exp   [6];
        SYS = 8'hA5; P1 = 8'h3C; P2 = 8'hC3; DSW1 = 8'h5F; DSW2 = 8'h81;
        addrs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        exp   = '{8'hA5, 8'h3C, 8'hC3, 8'h5F, 8'h81, 8'hFF};
        IOCS = 1'b0; WR_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ADDR = addrs[i];
            tick();
            checks++;
            if (DOUT !== exp[i] || DOUT_EN !== 1'b1) begin
                errors++;
                $display("FAIL read_addr%0d: got dout=%h en=%b want dout=%h en=1", addrs[i], DOUT, DOUT_EN, exp[i]);
            end
        end
        IOCS = 1'b1;
        tick();
        checks++;
        if (DOUT_EN !== 1'b0 || DOUT !== 8'hFF) begin
            errors++; $display("FAIL read_release: got dout=%h en=%b want dout=ff en=0", DOUT, DOUT_EN);
        end
    endtask

    task automatic test_control_coin();
        int total;
        checks++;
        if (COIN1 !== 1'b0 || RMRD !== 1'b0) begin
            errors++; $display("FAIL coin_pre: got coin1=%b rmrd=%b want 0 0", COIN1, RMRD);
        end
        do_write(3'd0, 8'h21);
        checks++;
        if (COIN1 !== 1'b1 || RMRD !== 1'b1) begin
            errors++; $display("FAIL ctrl_write: got coin1=%b rmrd=%b want 1 1", COIN1, RMRD);
        end
        tick();
        do_write(3'd0, 8'h20);
        total = 3;
        tick();
        while (COIN1 && total < 40) begin
            total++;
            tick();
        end
        checks++;
        if (total !== 16) begin
            errors++; $display("FAIL coin1_width: got %0d cycles want 16", total);
        end
        checks++;
        if (RMRD !== 1'b1 || COIN2 !== 1'b0) begin
            errors++; $display("FAIL ctrl_hold: got rmrd=%b coin2=%b want 1 0", RMRD, COIN2);
        end
        do_write(3'd0, 8'h02);
        tick();
        do_write(3'd0, 8'h00);
        checks++;
        if (COIN2 !== 1'b1 || RMRD !== 1'b0) begin
            errors++; $display("FAIL coin2_stretch: got coin2=%b rmrd=%b want 1 0", COIN2, RMRD);
        end
        repeat (20) tick();
        checks++;
        if (COIN2 !== 1'b0) begin
            errors++; $display("FAIL coin2_end: got %b want 0", COIN2);
        end
    endtask

    task automatic test_sound();
        do_write(3'd1, 8'h5A);
        checks++;
        if (SND_DATA !== 8'h5A || SND_IRQ !== 1'b1) begin
            errors++; $display("FAIL snd_first: got data=%h irq=%b want 5a 1", SND_DATA, SND_IRQ);
        end
        tick();
        do_write(3'd1, 8'h6B);
        checks++;
        if (SND_DATA !== 8'h6B || SND_IRQ !== 1'b1) begin
            errors++; $display("FAIL snd_overwrite: got data=%h irq=%b want 6b 1", SND_DATA, SND_IRQ);
        end
        tick();
        SND_ACK = 1'b1;
        tick();
        SND_ACK = 1'b0;
        checks++;
        if (SND_IRQ !== 1'b0 || SND_DATA !== 8'h6B) begin
            errors++; $display("FAIL snd_ack: got data=%h irq=%b want 6b 0", SND_DATA, SND_IRQ);
        end
        tick();
        SND_ACK = 1'b1;
        do_write(3'd1, 8'h77);
        SND_ACK = 1'b0;
        checks++;
        if (SND_IRQ !== 1'b1 || SND_DATA !== 8'h77) begin
            errors++; $display("FAIL snd_write_vs_ack: got data=%h irq=%b want 77 1", SND_DATA, SND_IRQ);
        end
        tick();
    endtask

    task automatic test_long_strobe();
        IOCS = 1'b0; WR_n = 1'b0; ADDR = 3'd0; DIN = 8'h01;
        tick();
        DIN = 8'h20;
        repeat (4) tick();
        IOCS = 1'b1; WR_n = 1'b1;
        tick();
        checks++;
        if (RMRD !== 1'b0 || COIN1 !== 1'b1) begin
            errors++; $display("FAIL long_strobe_ctrl: got rmrd=%b coin1=%b want 0 1", RMRD, COIN1);
        end
        IOCS = 1'b0; WR_n = 1'b0; ADDR = 3'd1; DIN = 8'h11;
        tick();
        DIN = 8'h22;
        repeat (4) tick();
        IOCS = 1'b1; WR_n = 1'b1;
        tick();
        checks++;
        if (SND_DATA !== 8'h11) begin
            errors++; $display("FAIL long_strobe_snd: got %h want 11", SND_DATA);
        end
        do_write(3'd0, 8'h00);
        tick();
    endtask

    task automatic test_wdog_kicks();
        logic bad;
        int   n;
        int   hi;
        n = 0;
        while (WDOG_RST && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (WDOG_RST !== 1'b0) begin
            errors++; $display("FAIL wdog_idle_wait: got %b want 0", WDOG_RST);
        end
        do_write(3'd2, 8'h00);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (49) begin
                tick();
                if (WDOG_RST !== 1'b0) bad = 1'b1;
            end
            do_write(3'd2, 8'h00);
            if (WDOG_RST !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL wdog_kicked: got wdog_rst=1 want 0");
        end
        n = 0;
        while (!WDOG_RST && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 100) begin
            errors++; $display("FAIL wdog_timeout: got %0d cycles want 100", n);
        end
        hi = 0;
        while (WDOG_RST && hi < 50) begin
            hi++;
            tick();
        end
        checks++;
        if (hi !== 8) begin
            errors++; $display("FAIL wdog_pulse: got %0d cycles want 8", hi);
        end
    endtask

    task automatic test_wdog_terminal();
        int n;
        int hi;
        do_write(3'd2, 8'h00);
        repeat (99) tick();
        do_write(3'd2, 8'h00);
        checks++;
        if (WDOG_RST !== 1'b0) begin
            errors++; $display("FAIL wdog_terminal_kick: got %b want 0", WDOG_RST);
        end
        n = 0;
        while (!WDOG_RST && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 100) begin
            errors++; $display("FAIL wdog_after_terminal: got %0d cycles want 100", n);
        end
        hi = 1;
        do_write(3'd2, 8'h00);
        while (WDOG_RST && hi < 50) begin
            hi++;
            tick();
        end
        checks++;
        if (hi !== 8) begin
            errors++; $display("FAIL wdog_kick_in_pulse: got %0d cycles want 8", hi);
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (!WDOG_RST && n < 200) begin
            tick();
            n++;
        end
        tick();
        do_write(3'd1, 8'h33);
        tick();
        do_write(3'd0, 8'h01);
        checks++;
        if ({COIN1, WDOG_RST, SND_IRQ} !== 3'b111) begin
            errors++; $display("FAIL async_pre: got coin1/wdog/irq=%b want 111", {COIN1, WDOG_RST, SND_IRQ});
        end
        #1 RST_n = 1'b0;
        #1;
        checks++;
        if (out_vec() !== 22'h0) begin
            errors++; $display("FAIL async_reset: got %h want 000000", out_vec());
        end
        @(posedge CLK);
        #1 RST_n = 1'b1;
        tick();
    endtask

    initial begin
        RST_n = 1'b0; IOCS = 1'b1; WR_n = 1'b1; ADDR = 3'd0; DIN = 8'h00; SND_ACK = 1'b0;
        SYS = 8'h00; P1 = 8'h00; P2 = 8'h00; DSW1 = 8'h00; DSW2 = 8'h00;
        test_reset();
        test_reads();
        test_control_coin();
        test_sound();
        test_long_strobe();
        test_wdog_kicks();
        test_wdog_terminal();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aliens_io_regs.md
Name: aliens_io_regs

Overview:
- Synchronous I/O register block sitting directly downstream of the main-CPU address decoder PAL.
- Consumes the decoder's active-low IOCS strobe and low address bits.
- Implements the control register, sound-command latch with IRQ/ACK handshake, coin-counter pulse stretchers, watchdog, and the input-port read mux.
- Its RMRD output feeds back into the decoder's RMRD input.

Parameters:
- COIN_PULSE, 16, minimum high width of each coin-counter output, in CLK cycles (>=1).
- WDOG_MAX, 65535, CLK cycles without a kick before watchdog fires (>=2).
- WDOG_PULSE, 8, width of WDOG_RST pulse, in CLK cycles (>=1).

Ports:
- CLK  in  1  system clock; sole clock domain.
- RST_n  in  1  asynchronous active-low reset.
- IOCS  in  1  active-low I/O chip select from decoder; already synchronous to CLK.
- WR_n  in  1  CPU write strobe, active low.
- ADDR  in  3  CPU address bits 2:0 within the I/O window.
- DIN  in  8  CPU write data.
- DOUT  out  8  read data.
- DOUT_EN  out  1  high while DOUT is valid for the CPU bus.
- SYS  in  8  system inputs (coins, service).
- P1  in  8  player 1 inputs.
- P2  in  8  player 2 inputs.
- DSW1  in  8  dip switch bank 1.
- DSW2  in  8  dip switch bank 2.
- RMRD  out  1  control bit 5, to decoder.
- COIN1  out  1  coin counter 1 drive.
- COIN2  out  1  coin counter 2 drive.
- SND_DATA  out  8  sound command latch.
- SND_IRQ  out  1  sound CPU interrupt request, level.
- SND_ACK  in  1  sound CPU acknowledge, level, synchronous.
- WDOG_RST  out  1  main CPU reset request, active high.

Behaviour:
- Reset (RST_n low, async): RMRD=0, COIN1/COIN2=0, SND_DATA=0x00, SND_IRQ=0, WDOG_RST=0, DOUT=0x00, DOUT_EN=0. All counters are cleared.
- Access detect: acc = ~IOCS.
  - Write event = acc & ~WR_n in this cycle, with the previous cycle's write condition false. Rising-edge detect gives exactly one event per bus write, however long the strobe is held.
- Write map by ADDR:
  - 0: control. bit0 -> coin1 request, bit1 -> coin2 request, bit5 -> RMRD. Other bits are discarded. RMRD updates one cycle after the event.
  - 1: SND_DATA <= DIN, SND_IRQ <= 1, both one cycle after the event.
  - 2: watchdog kick; data ignored.
  - 3-7: ignored, no state change.
- Read: when acc & WR_n, DOUT <= mux(ADDR) and DOUT_EN <= 1 on the next edge, so latency is 1 cycle. When no longer true, DOUT_EN <= 0 next edge and DOUT holds.
  - Mux: 0 SYS, 1 P1, 2 P2, 3 DSW1, 4 DSW2, 5-7 0xFF.
- Coin stretchers: each coin output has its own counter.
  - A 0->1 transition of a control coin bit loads the counter with COIN_PULSE and drives COINx=1.
  - COINx stays 1 until the counter reaches 0, or for longer if the control bit is still 1. COINx = bit | (cnt != 0).
  - A new 0->1 while the counter is running reloads it (retrigger).
- Sound handshake:
  - SND_IRQ clears on the first cycle SND_ACK=1, provided no sound write event occurs in that same cycle. Write beats ACK when simultaneous; IRQ remains 1.
  - A write while SND_IRQ=1 overwrites SND_DATA; IRQ stays 1. There is no queueing.
  - SND_DATA is never cleared except by reset.
- Watchdog:
  - A cycle counter increments every CLK while WDOG_RST=0.
  - A kick clears it to 0.
  - When count reaches WDOG_MAX-1 without a kick: WDOG_RST=1 for exactly WDOG_PULSE cycles, then 0, with the counter cleared.
  - A kick in the same cycle as the terminal count wins: no pulse.
  - Kicks during an active pulse are ignored. The pulse always runs to completion.
  - WDOG_RST does not reset any other register in this block.
- Widths: counter widths come from $clog2(param+1); there is no wrap-around. Terminal values are saturating compares.

Test Plan:
- Reset: hold RST_n=0 with random inputs -> all outputs at reset values. Release; 10 idle cycles -> no output change.
- Reads: SYS=0xA5, P1=0x3C, DSW2=0x81, IOCS low WR_n high, ADDR 0/1/4/6 -> DOUT 0xA5/0x3C/0x81/0xFF one cycle later, with DOUT_EN=1 throughout. Deassert IOCS -> DOUT_EN=0 next cycle.
- Control/coin, COIN_PULSE=16:
  - Write 0x21 to addr 0 -> RMRD=1 and COIN1=1 after 1 cycle.
  - Write 0x20 two cycles later -> COIN1 stays 1 for 16 cycles total from rise, then 0; RMRD stays 1.
  - A 5-cycle-long write strobe yields a single event.
- Sound handshake:
  - Write 0x5A to addr 1 -> SND_DATA=0x5A, SND_IRQ=1.
  - Write 0x6B -> SND_DATA=0x6B, SND_IRQ still 1.
  - SND_ACK=1 -> SND_IRQ=0 next cycle.
  - Write coincident with SND_ACK -> SND_IRQ remains 1.
- Watchdog, WDOG_MAX=100, WDOG_PULSE=8:
  - Kick every 50 cycles -> WDOG_RST never asserts.
  - Stop kicking -> WDOG_RST=1 for exactly 8 cycles, 100 cycles after the last kick.
  - Kick on the terminal cycle -> no pulse.
  - Kick during the pulse -> pulse still 8 cycles.
- Async reset mid-operation: assert RST_n during an active coin stretch and watchdog pulse -> COIN1, WDOG_RST and SND_IRQ drop immediately, without waiting for a CLK edge.
